// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch controller with 2-entry buffer
// Optional misaligned-redirect trap: FETCH_MISALIGN_TRAP_EN
module instr_fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 128
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Halt,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    output logic [31:0] MemAddress,
    input  logic [31:0] MemInstruction,
    output logic        InstrValid,
    input  logic        InstrReady,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic        Busy,
    output logic        Misaligned
);

    // Keeps addresses word-aligned and inside the memory, giving wrap for free
    localparam logic [31:0] ADDR_MASK = 32'(MEM_WORDS * 4 - 1) & ~32'd3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state, next_state;
    logic [31:0] pc;
    logic [31:0] buf_instr [2];
    logic [31:0] buf_pc    [2];
    logic        rd_ptr, wr_ptr;
    logic [1:0]  count;
    logic        push, pop;
    logic        misalign_hit;
    logic        start_ok;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;

    assign misalign_hit = Redirect && (RedirectPC[1:0] != 2'b00);
    assign start_ok     = Start && !misaligned_q;
    assign Misaligned   = misaligned_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            misaligned_q <= 1'b0;
        else if (misalign_hit)
            misaligned_q <= 1'b1;
    end
`else
    assign misalign_hit = 1'b0;
    assign start_ok     = Start;
    assign Misaligned   = 1'b0;
`endif

    assign InstrValid = (count != 2'd0);
    assign pop        = InstrValid && InstrReady;
    assign push       = (state == RUN) && !Redirect && ((count < 2'd2) || pop);
    assign MemAddress = pc;
    assign InstrOut   = InstrValid ? buf_instr[rd_ptr] : 32'd0;
    assign InstrPC    = InstrValid ? buf_pc[rd_ptr]    : 32'd0;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (misalign_hit) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (!Redirect && start_ok) next_state = RUN;
                RUN:     if (Halt) next_state = DRAIN;
                DRAIN:   if (Redirect || count == 2'd0) next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        Busy = (state != IDLE);
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pc     <= RESET_PC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_instr[i] <= 32'd0;
                buf_pc[i]    <= 32'd0;
            end
        end else if (Redirect) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            if (!misalign_hit)
                pc <= RedirectPC & ADDR_MASK;
        end else begin
            if (push) begin
                buf_instr[wr_ptr] <= MemInstruction;
                buf_pc[wr_ptr]    <= pc;
                wr_ptr            <= ~wr_ptr;
                pc                <= (pc + 32'd4) & ADDR_MASK;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have parameter MEM_WORDS, default 128, instruction memory depth in 32-bit words (power of two).
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start  input  1  leave IDLE and begin fetching.
REQ-006 SHALL have port Halt  input  1  stop issuing fetches and drain the buffer.
REQ-007 SHALL have port Redirect  input  1  flush and load a new PC.
REQ-008 SHALL have port RedirectPC  input  32  byte address of the redirect target.
REQ-009 SHALL have port MemAddress  output  32  byte address driven to instruction memory.
REQ-010 SHALL have port MemInstruction  input  32  word returned combinationally by instruction memory.
REQ-011 SHALL have port InstrValid  output  1  head buffer entry valid.
REQ-012 SHALL have port InstrReady  input  1  consumer accepts the head entry.
REQ-013 SHALL have port InstrOut  output  32  head entry instruction; 0 when InstrValid=0.
REQ-014 SHALL have port InstrPC  output  32  head entry byte address; 0 when InstrValid=0.
REQ-015 SHALL have port Busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port Misaligned  output  1  sticky misaligned-redirect flag (see Configuration).

Function
REQ-017 SHALL implement states IDLE, RUN, DRAIN: IDLE->RUN on Start; RUN->DRAIN on Halt; DRAIN->IDLE once the buffer is empty; Start is ignored outside IDLE; Halt is ignored in IDLE.
REQ-018 SHALL drive MemAddress = PC continuously, with PC always word-aligned and below MEM_WORDS*4.
REQ-019 SHALL contain a 2-entry FIFO of {instruction, PC}; InstrValid = (count != 0); a pop occurs on an edge where InstrValid && InstrReady.
REQ-020 SHALL, in RUN with no Redirect, push {MemInstruction, PC} and advance PC by 4 on each edge where count<2 or a pop occurs in the same cycle; push and pop in the same cycle leave the count unchanged.
REQ-021 SHALL wrap the PC modulo MEM_WORDS*4 (0x1FC + 4 -> 0x000 at the default depth).
REQ-022 SHALL not push in IDLE or DRAIN; pops continue in DRAIN.
REQ-023 SHALL, on Redirect in any state, empty the FIFO, load PC <= RedirectPC mod MEM_WORDS*4, and perform no push that cycle; the state is otherwise unchanged, except that DRAIN goes to IDLE.
REQ-024 SHALL give Redirect priority over Halt; when both occur in RUN, the flush is applied and the state goes to DRAIN, which then exits to IDLE on the next edge.
REQ-025 SHALL deliver the first instruction with InstrValid high on the second rising edge after the edge that samples Start, and sustain one instruction per cycle while InstrReady=1.

Reset
REQ-026 SHALL, while Rst_n=0 and independent of Clk, force: state IDLE, PC=RESET_PC, FIFO count 0, InstrValid 0, InstrOut 0, InstrPC 0, Busy 0, Misaligned 0.
REQ-027 SHALL discard all buffered entries on reset mid-operation, and SHALL resume only after a new Start.

Configuration
REQ-028 SHALL honour macro FETCH_MISALIGN_TRAP_EN. When it is defined, a Redirect with RedirectPC[1:0]!=0 SHALL leave PC unchanged, flush the FIFO, go to IDLE, and set Misaligned=1 sticky until reset; Start is ignored while Misaligned=1.
REQ-029 SHALL, when FETCH_MISALIGN_TRAP_EN is undefined, ignore RedirectPC[1:0] (treat them as 00) and tie Misaligned to 0.

Verification (memory word i preloaded with 3*i, MEM_WORDS=128)
REQ-030 Reset, Start pulse, InstrReady=1 -> InstrValid rises 2 edges after Start; the output stream is (0x0,PC 0x000), (0x3,0x004), (0x6,0x008), one per cycle, and Busy=1.
REQ-031 InstrReady=0 after Start -> count saturates at 2, MemAddress holds 0x008; when InstrReady rises, the stream is 0x0, 0x3, 0x6 in order with no loss or duplication.
REQ-032 Redirect to 0x1F8 in RUN -> the stream is (0x17A,0x1F8), (0x17D,0x1FC), (0x0,0x000), which exercises wrap.
REQ-033 Redirect to 0x040 with the FIFO full -> InstrValid=0 for one cycle, then (0x30,0x040); the stale entries never appear.
REQ-034 Halt with 2 entries and InstrReady=0 -> state DRAIN, Busy=1, MemAddress frozen; when InstrReady rises, 2 pops occur, then IDLE and Busy=0.
REQ-035 Redirect to 0x042 -> with FETCH_MISALIGN_TRAP_EN, Misaligned=1, IDLE, PC unchanged, and a subsequent Start is ignored; without the macro, fetching resumes at (0x30,0x040).
